branch_predictor: RTL and testbench

//  Fetch-side counterpart to EX-stage branch resolution. Gives IF a direction + target

---
 rtl/branch_predictor.sv | 127 ++++++++++++
 tb/tb_branch_predictor.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, trained from EX,
// plus a registered one-cycle redirect/flush on mispredict and a perf counter.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_cond,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [15:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         cnt_q [ENTRIES];
  logic [1:0]         cnt_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];

  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [15:0]     mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             upd, is_jump, taken_eff, mis, alloc;
  logic [XLEN-1:0]  correct_pc;
  logic             unused_bits;

  assign unused_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

  // Lookup sees only registered table state, so a same-cycle train is not bypassed.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && cnt_q[if_idx][1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + XLEN'(4);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // The instruction sitting in EX during a redirect cycle is wrong-path and dropped.
  assign upd        = ex_valid && (ex_is_cond || ex_is_jump) && !redirect_valid_q;
  assign is_jump    = ex_is_jump;
  assign taken_eff  = is_jump || ex_taken;
  assign correct_pc = taken_eff ? ex_target : ex_pc + XLEN'(4);
  assign mis        = upd && ((taken_eff != ex_pred_taken) ||
                              (taken_eff && (ex_target != ex_pred_target)));

  always_comb begin
    valid_d          = valid_q;
    cnt_d            = cnt_q;
    alloc            = 1'b0;
    redirect_valid_d = mis;
    redirect_pc_d    = mis ? correct_pc : redirect_pc_q;
    mispred_cnt_d    = mispred_cnt_q;
    if (mis && (mispred_cnt_q != 16'hFFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 16'd1;
    end
    if (upd) begin
      if (is_jump) begin
        valid_d[ex_idx] = 1'b1;
        alloc           = 1'b1;
        cnt_d[ex_idx]   = 2'b11;
      end else if (ex_taken) begin
        valid_d[ex_idx] = 1'b1;
        alloc           = 1'b1;
        // A miss (cold or aliasing PC) restarts the counter at weak taken.
        if (!ex_hit) begin
          cnt_d[ex_idx] = 2'b10;
        end else if (cnt_q[ex_idx] != 2'b11) begin
          cnt_d[ex_idx] = cnt_q[ex_idx] + 2'd1;
        end
      end else if (ex_hit && (cnt_q[ex_idx] != 2'b00)) begin
        cnt_d[ex_idx] = cnt_q[ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      valid_q          <= valid_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  // Tag and target storage is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= ex_target;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush          = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: lookup, training,
// redirect timing, wrong-path suppression, aliasing and async reset.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_cond;
  logic        ex_is_jump;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] mispred_cnt;

  int checks;
  int failures;

  branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_pc(if_pc),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .ex_valid(ex_valid),
    .ex_pc(ex_pc),
    .ex_is_cond(ex_is_cond),
    .ex_is_jump(ex_is_jump),
    .ex_taken(ex_taken),
    .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush(flush),
    .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic cond, input logic jump, input logic taken,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    ex_is_cond     = cond;
    ex_is_jump     = jump;
    ex_taken       = taken;
    ex_pc          = pc;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic ex_idle;
    ex_valid   = 1'b0;
    ex_is_cond = 1'b0;
    ex_is_jump = 1'b0;
    ex_taken   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ex_idle();
    ex_pc = 32'h0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    if_pc = 32'h100;
    #3;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_pred_taken got=%b exp=0", pred_taken);
    end
    checks++;
    if (pred_target !== 32'h104) begin
      failures++; $display("[TB] FAIL reset_pred_target got=%h exp=00000104", pred_target);
    end
    checks++;
    if ({redirect_valid, flush, redirect_pc, mispred_cnt} !== 50'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got rv=%b fl=%b pc=%h cnt=%0d exp all 0",
               redirect_valid, flush, redirect_pc, mispred_cnt);
    end
    if_pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (pred_target !== 32'h0) begin
      failures++; $display("[TB] FAIL wrap_pred_target got=%h exp=00000000", pred_target);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cond_taken;
    if_pc = 32'h100;
    ex_drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++; $display("[TB] FAIL same_cycle_no_bypass got=%b exp=0", pred_taken);
    end
    tick();
    ex_idle();
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h80) begin
      failures++;
      $display("[TB] FAIL cond_taken_redirect got rv=%b fl=%b pc=%h exp rv=1 fl=1 pc=00000080",
               redirect_valid, flush, redirect_pc);
    end
    checks++;
    if (mispred_cnt !== 16'd1) begin
      failures++; $display("[TB] FAIL cond_taken_cnt got=%0d exp=1", mispred_cnt);
    end
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      failures++;
      $display("[TB] FAIL cond_taken_lookup got tk=%b tgt=%h exp tk=1 tgt=00000080",
               pred_taken, pred_target);
    end
    tick();
    checks++;
    if (redirect_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL redirect_one_cycle got=%b exp=0", redirect_valid);
    end
  endtask

  task automatic test_cond_not_taken;
    if_pc = 32'h100;
    ex_drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
    tick();
    ex_idle();
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104 || mispred_cnt !== 16'd2) begin
      failures++;
      $display("[TB] FAIL nt_first got rv=%b pc=%h cnt=%0d exp rv=1 pc=00000104 cnt=2",
               redirect_valid, redirect_pc, mispred_cnt);
    end
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      failures++;
      $display("[TB] FAIL nt_first_lookup got tk=%b tgt=%h exp tk=0 tgt=00000104",
               pred_taken, pred_target);
    end
    tick();
    ex_drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h104);
    tick();
    ex_idle();
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || mispred_cnt !== 16'd2 || redirect_pc !== 32'h104) begin
      failures++;
      $display("[TB] FAIL nt_second got rv=%b pc=%h cnt=%0d exp rv=0 pc=00000104 cnt=2",
               redirect_valid, redirect_pc, mispred_cnt);
    end
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++; $display("[TB] FAIL nt_second_lookup got=%b exp=0", pred_taken);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    ex_drive(1'b0, 1'b1, 1'b1, 32'h200, 32'h400, 1'b0, 32'h204);
    tick();
    ex_drive(1'b1, 1'b0, 1'b1, 32'h300, 32'h500, 1'b0, 32'h304);
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h400 || mispred_cnt !== 16'd3) begin
      failures++;
      $display("[TB] FAIL jal_redirect got rv=%b pc=%h cnt=%0d exp rv=1 pc=00000400 cnt=3",
               redirect_valid, redirect_pc, mispred_cnt);
    end
    tick();
    ex_idle();
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || mispred_cnt !== 16'd3 ||
        redirect_pc !== 32'h400) begin
      failures++;
      $display("[TB] FAIL wrong_path_ignored got rv=%b fl=%b pc=%h cnt=%0d exp rv=0 fl=0 pc=00000400 cnt=3",
               redirect_valid, flush, redirect_pc, mispred_cnt);
    end
    if_pc = 32'h300;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h304) begin
      failures++;
      $display("[TB] FAIL wrong_path_no_write got tk=%b tgt=%h exp tk=0 tgt=00000304",
               pred_taken, pred_target);
    end
    if_pc = 32'h200;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
      failures++;
      $display("[TB] FAIL jal_lookup got tk=%b tgt=%h exp tk=1 tgt=00000400",
               pred_taken, pred_target);
    end
  endtask

  task automatic test_saturation;
    if_pc = 32'h200;
    ex_drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h400, 1'b1, 32'h400);
    tick();
    ex_idle();
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || mispred_cnt !== 16'd3) begin
      failures++;
      $display("[TB] FAIL correct_pred_no_redirect got rv=%b cnt=%0d exp rv=0 cnt=3",
               redirect_valid, mispred_cnt);
    end
    ex_drive(1'b1, 1'b0, 1'b0, 32'h200, 32'h400, 1'b1, 32'h400);
    tick();
    ex_idle();
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204 || mispred_cnt !== 16'd4) begin
      failures++;
      $display("[TB] FAIL sat_nt_redirect got rv=%b pc=%h cnt=%0d exp rv=1 pc=00000204 cnt=4",
               redirect_valid, redirect_pc, mispred_cnt);
    end
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
      failures++;
      $display("[TB] FAIL sat_counter_held got tk=%b tgt=%h exp tk=1 tgt=00000400",
               pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_alias;
    for (int k = 0; k < 2; k++) begin
      ex_drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
      tick();
      ex_idle();
      tick();
    end
    if_pc = 32'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80 || mispred_cnt !== 16'd6) begin
      failures++;
      $display("[TB] FAIL retrain_0x100 got tk=%b tgt=%h cnt=%0d exp tk=1 tgt=00000080 cnt=6",
               pred_taken, pred_target, mispred_cnt);
    end
    ex_drive(1'b1, 1'b0, 1'b1, 32'h140, 32'h600, 1'b0, 32'h144);
    tick();
    ex_idle();
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h600 || mispred_cnt !== 16'd7) begin
      failures++;
      $display("[TB] FAIL alias_redirect got rv=%b pc=%h cnt=%0d exp rv=1 pc=00000600 cnt=7",
               redirect_valid, redirect_pc, mispred_cnt);
    end
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      failures++;
      $display("[TB] FAIL alias_evicts got tk=%b tgt=%h exp tk=0 tgt=00000104",
               pred_taken, pred_target);
    end
    if_pc = 32'h140;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h600) begin
      failures++;
      $display("[TB] FAIL alias_new_owner got tk=%b tgt=%h exp tk=1 tgt=00000600",
               pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    ex_drive(1'b0, 1'b1, 1'b1, 32'h200, 32'h800, 1'b1, 32'h400);
    tick();
    ex_idle();
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h800 || mispred_cnt !== 16'd8) begin
      failures++;
      $display("[TB] FAIL target_mispredict got rv=%b pc=%h cnt=%0d exp rv=1 pc=00000800 cnt=8",
               redirect_valid, redirect_pc, mispred_cnt);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({redirect_valid, flush, redirect_pc, mispred_cnt} !== 50'd0) begin
      failures++;
      $display("[TB] FAIL async_reset_outputs got rv=%b fl=%b pc=%h cnt=%0d exp all 0",
               redirect_valid, flush, redirect_pc, mispred_cnt);
    end
    if_pc = 32'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      failures++;
      $display("[TB] FAIL async_reset_valid_clear got tk=%b tgt=%h exp tk=0 tgt=00000104",
               pred_taken, pred_target);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (redirect_valid !== 1'b0 || mispred_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle got rv=%b cnt=%0d exp rv=0 cnt=0",
               redirect_valid, mispred_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_cond_taken();
    test_cond_not_taken();
    test_back_to_back();
    test_saturation();
    test_alias();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
